// File: rtl/alu_issue_if.sv
// Upstream/downstream handshake and payload bundle for the alu_issue stage.
// The DUT binds the slave modport; the producer/consumer side binds master.
interface alu_issue_if;
    logic        iValid;
    logic        oReady;
    logic [31:0] iInstr;
    logic [31:0] iRsData;
    logic [31:0] iRtData;
    logic        iFlush;
    logic        iWbEn;
    logic [4:0]  iWbAddr;
    logic [31:0] iWbData;
    logic        oValid;
    logic        iReady;
    logic [31:0] oA;
    logic [31:0] oB;
    logic [5:0]  oALUFun;
    logic        oSign;
    logic [4:0]  oDst;
    logic        oRegWr;
    logic        oMemRd;
    logic        oMemWr;
    logic        oBranch;
    logic        oIllegal;
    logic        oIllegalSeen;

    modport master (
        output iValid, iInstr, iRsData, iRtData, iFlush, iWbEn, iWbAddr, iWbData, iReady,
        input  oReady, oValid, oA, oB, oALUFun, oSign, oDst,
               oRegWr, oMemRd, oMemWr, oBranch, oIllegal, oIllegalSeen
    );

    modport slave (
        input  iValid, iInstr, iRsData, iRtData, iFlush, iWbEn, iWbAddr, iWbData, iReady,
        output oReady, oValid, oA, oB, oALUFun, oSign, oDst,
               oRegWr, oMemRd, oMemWr, oBranch, oIllegal, oIllegalSeen
    );
endinterface

// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes a MIPS word into ALU operands/function and holds them in one
// handshaked register. Optional writeback bypass is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue (
    input logic        iClk,
    input logic        iRst_n,
    alu_issue_if.slave bus
);
    localparam logic [5:0] FunAdd = 6'b000000;
    localparam logic [5:0] FunSub = 6'b000001;
    localparam logic [5:0] FunAnd = 6'b011000;
    localparam logic [5:0] FunOr  = 6'b011110;
    localparam logic [5:0] FunXor = 6'b010110;
    localparam logic [5:0] FunNor = 6'b010001;
    localparam logic [5:0] FunSll = 6'b100000;
    localparam logic [5:0] FunSrl = 6'b100001;
    localparam logic [5:0] FunSra = 6'b100011;
    localparam logic [5:0] FunEq  = 6'b110011;
    localparam logic [5:0] FunNeq = 6'b110001;
    localparam logic [5:0] FunLt  = 6'b110101;
    localparam logic [5:0] FunLez = 6'b111101;
    localparam logic [5:0] FunGez = 6'b111001;
    localparam logic [5:0] FunGtz = 6'b111111;

    logic [5:0]         op;
    logic [5:0]         funct;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [4:0]         shamt;
    logic [15:0]        imm;
    logic signed [31:0] immSext;
    logic [31:0]        immZext;
    logic [31:0]        rsVal;
    logic [31:0]        rtVal;

    assign op      = bus.iInstr[31:26];
    assign rs      = bus.iInstr[25:21];
    assign rt      = bus.iInstr[20:16];
    assign rd      = bus.iInstr[15:11];
    assign shamt   = bus.iInstr[10:6];
    assign funct   = bus.iInstr[5:0];
    assign imm     = bus.iInstr[15:0];
    assign immSext = {{16{imm[15]}}, imm};
    assign immZext = {16'd0, imm};

`ifdef ALU_ISSUE_FWD_EN
    // Bypass only replaces register reads; shamt/immediate/zero operands come after this.
    assign rsVal = (bus.iWbEn && (bus.iWbAddr != 5'd0) && (bus.iWbAddr == rs)) ? bus.iWbData : bus.iRsData;
    assign rtVal = (bus.iWbEn && (bus.iWbAddr != 5'd0) && (bus.iWbAddr == rt)) ? bus.iWbData : bus.iRtData;
`else
    logic unusedWb;
    assign unusedWb = ^{bus.iWbEn, bus.iWbAddr, bus.iWbData};
    assign rsVal    = bus.iRsData;
    assign rtVal    = bus.iRtData;
`endif

    logic [31:0] dA;
    logic [31:0] dB;
    logic [5:0]  dFun;
    logic        dSign;
    logic [4:0]  dDst;
    logic        dRegWr;
    logic        dMemRd;
    logic        dMemWr;
    logic        dBranch;
    logic        dIllegal;

    always_comb begin
        dFun     = FunAdd;
        dA       = '0;
        dB       = '0;
        dSign    = 1'b0;
        dDst     = '0;
        dRegWr   = 1'b0;
        dMemRd   = 1'b0;
        dMemWr   = 1'b0;
        dBranch  = 1'b0;
        dIllegal = 1'b0;
        case (op)
            6'h00: begin
                dA     = rsVal;
                dB     = rtVal;
                dDst   = rd;
                dRegWr = 1'b1;
                case (funct)
                    6'h20: begin dFun = FunAdd; dSign = 1'b1; end
                    6'h21: dFun = FunAdd;
                    6'h22: begin dFun = FunSub; dSign = 1'b1; end
                    6'h23: dFun = FunSub;
                    6'h24: dFun = FunAnd;
                    6'h25: dFun = FunOr;
                    6'h26: dFun = FunXor;
                    6'h27: dFun = FunNor;
                    6'h2A: begin dFun = FunLt; dSign = 1'b1; end
                    6'h2B: dFun = FunLt;
                    6'h00: begin dFun = FunSll; dA = {27'd0, shamt}; end
                    6'h02: begin dFun = FunSrl; dA = {27'd0, shamt}; end
                    6'h03: begin dFun = FunSra; dA = {27'd0, shamt}; end
                    default: dIllegal = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
                dA     = rsVal;
                dB     = immSext;
                dDst   = rt;
                dRegWr = (op != 6'h2B);
                dMemRd = (op == 6'h23);
                dMemWr = (op == 6'h2B);
                dSign  = (op != 6'h09) && (op != 6'h0B);
                dFun   = (op == 6'h0A || op == 6'h0B) ? FunLt : FunAdd;
            end
            6'h0C: begin dA = rsVal; dB = immZext; dDst = rt; dRegWr = 1'b1; dFun = FunAnd; end
            6'h0D: begin dA = rsVal; dB = immZext; dDst = rt; dRegWr = 1'b1; dFun = FunOr;  end
            6'h0E: begin dA = rsVal; dB = immZext; dDst = rt; dRegWr = 1'b1; dFun = FunXor; end
            6'h0F: begin dA = 32'd16; dB = immZext; dDst = rt; dRegWr = 1'b1; dFun = FunSll; end
            6'h04: begin dA = rsVal; dB = rtVal; dBranch = 1'b1; dSign = 1'b1; dFun = FunEq;  end
            6'h05: begin dA = rsVal; dB = rtVal; dBranch = 1'b1; dSign = 1'b1; dFun = FunNeq; end
            6'h06: begin dA = rsVal; dBranch = 1'b1; dSign = 1'b1; dFun = FunLez; end
            6'h07: begin dA = rsVal; dBranch = 1'b1; dSign = 1'b1; dFun = FunGtz; end
            6'h01: begin
                dA      = rsVal;
                dBranch = 1'b1;
                dSign   = 1'b1;
                case (rt)
                    5'd1:    dFun = FunGez;
                    5'd0:    dFun = FunLt;
                    default: dIllegal = 1'b1;
                endcase
            end
            default: dIllegal = 1'b1;
        endcase
        // Unsupported words collapse to an inert ADD 0,0 that still flows downstream.
        if (dIllegal) begin
            dFun    = FunAdd;
            dA      = '0;
            dB      = '0;
            dSign   = 1'b0;
            dDst    = '0;
            dRegWr  = 1'b0;
            dMemRd  = 1'b0;
            dMemWr  = 1'b0;
            dBranch = 1'b0;
        end else if (dDst == 5'd0) begin
            dRegWr = 1'b0;
        end
    end

    logic        vld_p1;
    logic [31:0] a_p1;
    logic [31:0] b_p1;
    logic [5:0]  fun_p1;
    logic        sign_p1;
    logic [4:0]  dst_p1;
    logic        regWr_p1;
    logic        memRd_p1;
    logic        memWr_p1;
    logic        branch_p1;
    logic        illegal_p1;
    logic        seen_p1;
    logic        accept;
    logic        load;

    assign bus.oReady = !vld_p1 || bus.iReady;
    assign accept     = bus.iValid && bus.oReady;
    assign load       = accept && !bus.iFlush;

    // Stage boundary: decode -> issue register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            vld_p1     <= 1'b0;
            a_p1       <= '0;
            b_p1       <= '0;
            fun_p1     <= '0;
            sign_p1    <= 1'b0;
            dst_p1     <= '0;
            regWr_p1   <= 1'b0;
            memRd_p1   <= 1'b0;
            memWr_p1   <= 1'b0;
            branch_p1  <= 1'b0;
            illegal_p1 <= 1'b0;
            seen_p1    <= 1'b0;
        end else begin
            if (bus.iFlush)      vld_p1 <= 1'b0;
            else if (accept)     vld_p1 <= 1'b1;
            else if (bus.iReady) vld_p1 <= 1'b0;
            if (load) begin
                a_p1       <= dA;
                b_p1       <= dB;
                fun_p1     <= dFun;
                sign_p1    <= dSign;
                dst_p1     <= dDst;
                regWr_p1   <= dRegWr;
                memRd_p1   <= dMemRd;
                memWr_p1   <= dMemWr;
                branch_p1  <= dBranch;
                illegal_p1 <= dIllegal;
                if (dIllegal) seen_p1 <= 1'b1;
            end
        end
    end

    assign bus.oValid       = vld_p1;
    assign bus.oA           = a_p1;
    assign bus.oB           = b_p1;
    assign bus.oALUFun      = fun_p1;
    assign bus.oSign        = sign_p1;
    assign bus.oDst         = dst_p1;
    assign bus.oRegWr       = regWr_p1;
    assign bus.oMemRd       = memRd_p1;
    assign bus.oMemWr       = memWr_p1;
    assign bus.oBranch      = branch_p1;
    assign bus.oIllegal     = illegal_p1;
    assign bus.oIllegalSeen = seen_p1;
endmodule
